alu_multicycle: RTL and testbench

//  Parametrised next-generation integer ALU for the core's execute stage.

---
 rtl/alu_multicycle.sv | 194 +++++++++++++++++++
 tb/tb_alu_multicycle.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_multicycle.sv
// Integer ALU with valid/ready handshakes; shifts and shift-add iterate SHIFT_STEP bits per cycle.
// Optional feature macro: ALU_ROTATE_EN enables rol/ror on the iterative shift path.
module alu_multicycle #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned SHIFT_STEP = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic [2:0]      f3,
  input  logic            arith_bit,
  input  logic            shadd,
  input  logic            branch,
  input  logic            rot,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int unsigned SHW = $clog2(XLEN);
  localparam int unsigned CW  = SHW + 1;

  typedef enum logic [1:0] {IDLE, SHIFT, ADD} state_e;
  typedef enum logic [2:0] {K_SLL, K_SRL, K_SRA, K_ROL, K_ROR} kind_e;

  state_e            state_q, state_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [XLEN-1:0]   work_q, work_d;
  logic [XLEN-1:0]   addend_q, addend_d;
  logic [CW-1:0]     remain_q, remain_d;
  kind_e             kind_q, kind_d;
  logic              shadd_q, shadd_d;

  logic              accept_c;
  logic              rot_sel_c;
  logic              is_shift_c;
  logic [CW-1:0]     shamt_c;
  logic [CW-1:0]     k_c;
  kind_e             kind_c;
  logic [XLEN-1:0]   single_c;
  logic [CW-1:0]     step_c;
  logic [CW-1:0]     remain_next_c;
  logic [XLEN-1:0]   stepped_c;
  logic              cond_c;

`ifdef ALU_ROTATE_EN
  assign rot_sel_c = rot;
`else
  logic unused_rot;
  assign unused_rot = rot;
  assign rot_sel_c  = 1'b0;
`endif

  assign req_ready = (state_q == IDLE) && (!rsp_valid_q || rsp_ready);
  assign accept_c  = req_valid && req_ready;
  assign rsp_valid = rsp_valid_q;
  assign result    = result_q;
  assign busy      = (state_q != IDLE);

  // Request decode: which ops go down the iterative path and in which direction
  always_comb begin
    shamt_c    = CW'(src_b[SHW-1:0]);
    k_c        = CW'(f3[2:1]);
    is_shift_c = !shadd && !branch && (f3[1:0] == 2'b01);
    if (rot_sel_c) begin
      kind_c = f3[2] ? K_ROR : K_ROL;
    end else if (f3[2]) begin
      kind_c = arith_bit ? K_SRA : K_SRL;
    end else begin
      kind_c = K_SLL;
    end
  end

  // Single-cycle results, including zero-distance shifts and k=0 shift-add
  always_comb begin
    single_c = '0;
    cond_c   = 1'b0;
    if (shadd) begin
      single_c = src_a + src_b;
    end else if (branch) begin
      case (f3)
        3'b000:  cond_c = (src_a == src_b);
        3'b001:  cond_c = (src_a != src_b);
        3'b100:  cond_c = ($signed(src_a) < $signed(src_b));
        3'b101:  cond_c = ($signed(src_a) >= $signed(src_b));
        3'b110:  cond_c = (src_a < src_b);
        3'b111:  cond_c = (src_a >= src_b);
        default: cond_c = 1'b0;
      endcase
      single_c = XLEN'(cond_c);
    end else begin
      case (f3)
        3'b000:  single_c = arith_bit ? (src_a - src_b) : (src_a + src_b);
        3'b010:  single_c = XLEN'($signed(src_a) < $signed(src_b));
        3'b011:  single_c = XLEN'(src_a < src_b);
        3'b100:  single_c = src_a ^ src_b;
        3'b110:  single_c = src_a | src_b;
        3'b111:  single_c = src_a & src_b;
        default: single_c = src_a;
      endcase
    end
  end

  // One iteration of the shifter: at most SHIFT_STEP bits this cycle
  always_comb begin
    step_c        = (remain_q > CW'(SHIFT_STEP)) ? CW'(SHIFT_STEP) : remain_q;
    remain_next_c = remain_q - step_c;
    case (kind_q)
      K_SRL:   stepped_c = work_q >> step_c;
      K_SRA:   stepped_c = XLEN'($signed(work_q) >>> step_c);
      K_ROL:   stepped_c = (work_q << step_c) | (work_q >> (CW'(XLEN) - step_c));
      K_ROR:   stepped_c = (work_q >> step_c) | (work_q << (CW'(XLEN) - step_c));
      default: stepped_c = work_q << step_c;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    rsp_valid_d = rsp_valid_q && !rsp_ready;
    result_d    = result_q;
    work_d      = work_q;
    addend_d    = addend_q;
    remain_d    = remain_q;
    kind_d      = kind_q;
    shadd_d     = shadd_q;
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          work_d   = src_a;
          addend_d = src_b;
          shadd_d  = shadd;
          kind_d   = shadd ? K_SLL : kind_c;
          if (is_shift_c && (shamt_c != '0)) begin
            remain_d = shamt_c;
            state_d  = SHIFT;
          end else if (shadd && (k_c != '0)) begin
            remain_d = k_c;
            state_d  = SHIFT;
          end else begin
            result_d    = single_c;
            rsp_valid_d = 1'b1;
          end
        end
      end
      SHIFT: begin
        work_d   = stepped_c;
        remain_d = remain_next_c;
        if (remain_next_c == '0) begin
          if (shadd_q) begin
            state_d = ADD;
          end else begin
            result_d    = stepped_c;
            rsp_valid_d = 1'b1;
            state_d     = IDLE;
          end
        end
      end
      ADD: begin
        result_d    = work_q + addend_q;
        rsp_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rsp_valid_q <= 1'b0;
      result_q    <= '0;
      work_q      <= '0;
      addend_q    <= '0;
      remain_q    <= '0;
      kind_q      <= K_SLL;
      shadd_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= rsp_valid_d;
      result_q    <= result_d;
      work_q      <= work_d;
      addend_q    <= addend_d;
      remain_q    <= remain_d;
      kind_q      <= kind_d;
      shadd_q     <= shadd_d;
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed and randomized checks of alu_multicycle (XLEN=32, SHIFT_STEP=4) against a behavioural model.
module tb_alu_multicycle;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic [2:0]  f3;
  logic        arith_bit;
  logic        shadd;
  logic        branch;
  logic        rot;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] result;
  logic        busy;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  alu_multicycle #(.XLEN(32), .SHIFT_STEP(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .src_a(src_a), .src_b(src_b), .f3(f3), .arith_bit(arith_bit),
    .shadd(shadd), .branch(branch), .rot(rot), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .result(result), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Behavioural model: results straight from the instruction definitions
  function automatic logic [31:0] ref_result(input logic [31:0] a, input logic [31:0] b,
                                             input logic [2:0] f, input logic ar,
                                             input logic sh, input logic br, input logic rt);
    int unsigned     amt;
    logic signed [31:0] sa;
    logic [63:0]     dbl;
    amt = b % 32;
    sa  = a;
    if (sh) return (a << f[2:1]) + b;
    if (br) begin
      case (f)
        3'b000:  return (a == b) ? 32'd1 : 32'd0;
        3'b001:  return (a != b) ? 32'd1 : 32'd0;
        3'b100:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        3'b101:  return ($signed(a) >= $signed(b)) ? 32'd1 : 32'd0;
        3'b110:  return (a < b) ? 32'd1 : 32'd0;
        3'b111:  return (a >= b) ? 32'd1 : 32'd0;
        default: return 32'd0;
      endcase
    end
`ifdef ALU_ROTATE_EN
    if (rt && (f == 3'b001)) begin
      dbl = {a, a} << amt;
      return dbl[63:32];
    end
    if (rt && (f == 3'b101)) begin
      dbl = {a, a} >> amt;
      return dbl[31:0];
    end
`else
    dbl = {63'd0, rt};
`endif
    case (f)
      3'b000:  return ar ? (a - b) : (a + b);
      3'b001:  return a << amt;
      3'b010:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'b011:  return (a < b) ? 32'd1 : 32'd0;
      3'b100:  return a ^ b;
      3'b110:  return a | b;
      3'b111:  return a & b;
      default: begin
        if (ar) return sa >>> amt;
        return a >> amt;
      end
    endcase
  endfunction

  function automatic int ref_latency(input logic [31:0] b, input logic [2:0] f,
                                     input logic sh, input logic br);
    int amt;
    int k;
    amt = b % 32;
    k   = f / 2;
    if (sh) return (k == 0) ? 1 : 2 + (k + 3) / 4;
    if (!br && (f == 3'b001 || f == 3'b101)) return (amt == 0) ? 1 : 1 + (amt + 3) / 4;
    return 1;
  endfunction

  // Issue one request with rsp_ready high and check result and latency
  task automatic run_exp(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] f, input logic ar, input logic sh,
                         input logic br, input logic rt,
                         input logic [31:0] exp_r, input int exp_l);
    int guard;
    int lat;
    @(negedge clk);
    src_a = a; src_b = b; f3 = f; arith_bit = ar; shadd = sh; branch = br; rot = rt;
    req_valid = 1'b1; rsp_ready = 1'b1;
    guard = 0;
    while (!req_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check({tag, " result"}, result, exp_r);
    check({tag, " latency"}, 32'(lat), 32'(exp_l));
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic [2:0]  rf;
    logic        rar, rsh, rbr, rrt;
    int          cat;

    rst = 1'b1; req_valid = 1'b0; src_a = '0; src_b = '0; f3 = '0;
    arith_bit = 1'b0; shadd = 1'b0; branch = 1'b0; rot = 1'b0; rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset result", result, 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset req_ready", 32'(req_ready), 32'd1);

    run_exp("add", 32'd5, 32'd7, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 32'd12, 1);
    run_exp("sub", 32'd5, 32'd7, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFE, 1);
    run_exp("sra", 32'h8000_0000, 32'd31, 3'b101, 1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 9);
    run_exp("srl", 32'h8000_0000, 32'd31, 3'b101, 1'b0, 1'b0, 1'b0, 1'b0, 32'd1, 9);
    run_exp("sll5", 32'h0000_0003, 32'd5, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0060, 3);
    run_exp("sll0", 32'hDEAD_BEEF, 32'h0000_0020, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF, 1);
    run_exp("sh3add", 32'd3, 32'd10, 3'b110, 1'b0, 1'b1, 1'b0, 1'b0, 32'd34, 3);
    run_exp("sh0add", 32'd3, 32'd10, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 32'd13, 1);
    run_exp("bltu", 32'd1, 32'hFFFF_FFFF, 3'b110, 1'b0, 1'b0, 1'b1, 1'b0, 32'd1, 1);
    run_exp("blt", 32'd1, 32'hFFFF_FFFF, 3'b100, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 1);
    run_exp("b010", 32'd4, 32'd4, 3'b010, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 1);
`ifdef ALU_ROTATE_EN
    run_exp("rol", 32'h8000_0001, 32'd4, 3'b001, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0018, 2);
`endif

    // Backpressure: response held, then drain and accept in the same cycle
    @(negedge clk);
    src_a = 32'd9; src_b = 32'd4; f3 = 3'b000; arith_bit = 1'b0;
    shadd = 1'b0; branch = 1'b0; rot = 1'b0; req_valid = 1'b1; rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    check("stall rsp_valid", 32'(rsp_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall result held", result, 32'd13);
      check("stall req_ready", 32'(req_ready), 32'd0);
    end
    src_a = 32'h0000_00F0; src_b = 32'h0000_00FF; f3 = 3'b100;
    req_valid = 1'b1; rsp_ready = 1'b1;
    #1;
    check("drain req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    check("no bubble rsp_valid", 32'(rsp_valid), 32'd1);
    check("no bubble result", result, 32'h0000_000F);

    // Reset in the middle of a long shift
    @(negedge clk);
    src_a = 32'hF000_0000; src_b = 32'd20; f3 = 3'b101; arith_bit = 1'b0;
    req_valid = 1'b1; rsp_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    check("shift busy", 32'(busy), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid rst rsp_valid", 32'(rsp_valid), 32'd0);
    check("mid rst busy", 32'(busy), 32'd0);
    check("mid rst req_ready", 32'(req_ready), 32'd1);
    repeat (5) begin
      @(negedge clk);
      check("abandoned op silent", 32'(rsp_valid), 32'd0);
    end

    // Randomized ops against the model
    for (int n = 0; n < 80; n++) begin
      cat = $urandom_range(0, 3);
      ra  = $urandom;
      rb  = $urandom;
      rf  = 3'($urandom_range(0, 7));
      rar = 1'($urandom_range(0, 1));
      rrt = 1'($urandom_range(0, 1));
      rsh = (cat == 2);
      rbr = (cat == 1);
      if (cat == 3) rf = ($urandom_range(0, 1) == 0) ? 3'b001 : 3'b101;
      run_exp("random", ra, rb, rf, rar, rsh, rbr, rrt,
              ref_result(ra, rb, rf, rar, rsh, rbr, rrt), ref_latency(rb, rf, rsh, rbr));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
